// File: rtl/trace_checker.sv
// trace_checker: in-order execution-trace checker for the MIPS core.
// Watches pc/aluout/readdata/writedata and compares them against a loadable
// table of checkpoints (STORE, LOAD, FLOW). It counts mismatches with a
// saturating counter, ends a stalled run with a timeout, and reports pass/fail.
//
// Optional feature: define TRACE_CHK_FIRSTERR_EN to latch the index and
// observed value of the first error of a run. Without it, first_err_* are 0.
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   cfg_we_i/cfg_addr_i       table write strobe and index (honoured in IDLE only)
//   cfg_kind_i                0 STORE, 1 LOAD, 2/3 FLOW
//   cfg_pc_i/cfg_a_i/cfg_b_i  entry PC, expected aluout (or next PC), expected data
//   cfg_len_i                 number of valid entries, sampled on start_i
//   start_i                   one-cycle run request from IDLE or DONE
//   pc_i, aluout_i,
//   readdata_i, writedata_i   observed core signals
//   busy_o, done_o, pass_o,
//   timeout_o, err_cnt_o      run status
//   first_err_idx_o/obs_o     first failing entry and its observed value
module trace_checker #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ERR_W   = 8,
    parameter int unsigned TIMEOUT = 64,
    localparam int unsigned AW     = $clog2(DEPTH),
    localparam int unsigned TW     = $clog2(TIMEOUT)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cfg_we_i,
    input  logic [AW-1:0]     cfg_addr_i,
    input  logic [1:0]        cfg_kind_i,
    input  logic [DATA_W-1:0] cfg_pc_i,
    input  logic [DATA_W-1:0] cfg_a_i,
    input  logic [DATA_W-1:0] cfg_b_i,
    input  logic [AW:0]       cfg_len_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [DATA_W-1:0] aluout_i,
    input  logic [DATA_W-1:0] readdata_i,
    input  logic [DATA_W-1:0] writedata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              timeout_o,
    output logic [ERR_W-1:0]  err_cnt_o,
    output logic [AW-1:0]     first_err_idx_o,
    output logic [DATA_W-1:0] first_err_obs_o
);

    typedef enum logic [1:0] {StIdle, StRun, StFlowChk, StDone} state_e;

    // Checkpoint table; contents survive reset.
    logic [1:0]        kind_mem [DEPTH];
    logic [DATA_W-1:0] pc_mem   [DEPTH];
    logic [DATA_W-1:0] a_mem    [DEPTH];
    logic [DATA_W-1:0] b_mem    [DEPTH];

    state_e            state_q;
    logic [AW:0]       idx_q;
    logic [AW:0]       len_q;
    logic [TW-1:0]     tcnt_q;
    logic [ERR_W-1:0]  err_cnt_q;
    logic              busy_q, done_q, pass_q, timeout_q;

    always_ff @(posedge clk_i) begin
        if (cfg_we_i && state_q == StIdle) begin
            kind_mem[cfg_addr_i] <= cfg_kind_i;
            pc_mem[cfg_addr_i]   <= cfg_pc_i;
            a_mem[cfg_addr_i]    <= cfg_a_i;
            b_mem[cfg_addr_i]    <= cfg_b_i;
        end
    end

    logic [1:0]        cur_kind;
    logic [DATA_W-1:0] cur_pc, cur_a, cur_b, data_obs;
    logic              pc_hit, is_flow, a_ok, b_ok, sl_err, flow_err, err_sat, tc_end;

    always_comb begin
        cur_kind = kind_mem[idx_q[AW-1:0]];
        cur_pc   = pc_mem[idx_q[AW-1:0]];
        cur_a    = a_mem[idx_q[AW-1:0]];
        cur_b    = b_mem[idx_q[AW-1:0]];
        is_flow  = cur_kind[1];
        // LOAD checks readdata, STORE checks writedata.
        data_obs = cur_kind[0] ? readdata_i : writedata_i;
        pc_hit   = (pc_i == cur_pc);
        a_ok     = (aluout_i == cur_a);
        b_ok     = (data_obs == cur_b);
        sl_err   = !(a_ok && b_ok);
        flow_err = (pc_i != cur_a);
        err_sat  = (err_cnt_q == {ERR_W{1'b1}});
        tc_end   = (tcnt_q == TW'(TIMEOUT - 1));
    end

`ifdef TRACE_CHK_FIRSTERR_EN
    logic [AW-1:0]     first_idx_q;
    logic [DATA_W-1:0] first_obs_q;
    logic [DATA_W-1:0] sl_obs;
    // Report aluout when it is the failing compare, else the data bus.
    assign sl_obs = a_ok ? data_obs : aluout_i;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            len_q     <= '0;
            tcnt_q    <= '0;
            err_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
`ifdef TRACE_CHK_FIRSTERR_EN
            first_idx_q <= '0;
            first_obs_q <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_i) begin
                        err_cnt_q <= '0;
                        timeout_q <= 1'b0;
                        idx_q     <= '0;
                        tcnt_q    <= '0;
                        len_q     <= cfg_len_i;
`ifdef TRACE_CHK_FIRSTERR_EN
                        first_idx_q <= '0;
                        first_obs_q <= '0;
`endif
                        if (cfg_len_i == '0) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= 1'b1;
                        end else begin
                            state_q <= StRun;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                            pass_q  <= 1'b0;
                        end
                    end
                end
                StRun: begin
                    if (idx_q == len_q) begin
                        // Last entry was consumed on the previous edge.
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_cnt_q == '0) && !timeout_q;
                    end else if (pc_hit) begin
                        // A match beats the timeout boundary on the same cycle.
                        if (is_flow) begin
                            state_q <= StFlowChk;
                        end else begin
                            if (sl_err) begin
                                if (!err_sat) err_cnt_q <= err_cnt_q + 1'b1;
`ifdef TRACE_CHK_FIRSTERR_EN
                                if (err_cnt_q == '0) begin
                                    first_idx_q <= idx_q[AW-1:0];
                                    first_obs_q <= sl_obs;
                                end
`endif
                            end
                            idx_q  <= idx_q + 1'b1;
                            tcnt_q <= '0;
                        end
                    end else if (tc_end) begin
                        timeout_q <= 1'b1;
                        state_q   <= StDone;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        pass_q    <= 1'b0;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                StFlowChk: begin
                    if (flow_err) begin
                        if (!err_sat) err_cnt_q <= err_cnt_q + 1'b1;
`ifdef TRACE_CHK_FIRSTERR_EN
                        if (err_cnt_q == '0) begin
                            first_idx_q <= idx_q[AW-1:0];
                            first_obs_q <= pc_i;
                        end
`endif
                    end
                    idx_q   <= idx_q + 1'b1;
                    tcnt_q  <= '0;
                    state_q <= StRun;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // busy covers the whole run, including the FLOW check cycle.
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign pass_o    = pass_q;
    assign timeout_o = timeout_q;
    assign err_cnt_o = err_cnt_q;

`ifdef TRACE_CHK_FIRSTERR_EN
    assign first_err_idx_o = first_idx_q;
    assign first_err_obs_o = first_obs_q;
`else
    assign first_err_idx_o = '0;
    assign first_err_obs_o = '0;
`endif

endmodule

// File: tb/tb_trace_checker.sv
// Directed bench for trace_checker (DEPTH=8, ERR_W=2, TIMEOUT=8).
module tb_trace_checker;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 3;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          cfg_we_i = 1'b0;
    logic [AW-1:0] cfg_addr_i = '0;
    logic [1:0]    cfg_kind_i = '0;
    logic [DW-1:0] cfg_pc_i = '0, cfg_a_i = '0, cfg_b_i = '0;
    logic [AW:0]   cfg_len_i = '0;
    logic          start_i = 1'b0;
    logic [DW-1:0] pc_i = '0, aluout_i = '0, readdata_i = '0, writedata_i = '0;
    logic          busy_o, done_o, pass_o, timeout_o;
    logic [1:0]    err_cnt_o;
    logic [AW-1:0] first_err_idx_o;
    logic [DW-1:0] first_err_obs_o;

    int n_cmp = 0;
    int n_bad = 0;

    trace_checker #(.DATA_W(32), .DEPTH(8), .ERR_W(2), .TIMEOUT(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i),
        .cfg_kind_i(cfg_kind_i), .cfg_pc_i(cfg_pc_i), .cfg_a_i(cfg_a_i), .cfg_b_i(cfg_b_i),
        .cfg_len_i(cfg_len_i), .start_i(start_i), .pc_i(pc_i), .aluout_i(aluout_i),
        .readdata_i(readdata_i), .writedata_i(writedata_i), .busy_o(busy_o), .done_o(done_o),
        .pass_o(pass_o), .timeout_o(timeout_o), .err_cnt_o(err_cnt_o),
        .first_err_idx_o(first_err_idx_o), .first_err_obs_o(first_err_obs_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic write_entry(input logic [AW-1:0] a, input logic [1:0] k,
                               input logic [DW-1:0] p, input logic [DW-1:0] ea,
                               input logic [DW-1:0] eb);
        cfg_we_i = 1'b1; cfg_addr_i = a; cfg_kind_i = k;
        cfg_pc_i = p; cfg_a_i = ea; cfg_b_i = eb;
        tick();
        cfg_we_i = 1'b0;
    endtask

    task automatic do_start(input logic [AW:0] len);
        cfg_len_i = len; start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic drive(input logic [DW-1:0] p, input logic [DW-1:0] al,
                         input logic [DW-1:0] rd, input logic [DW-1:0] wd);
        pc_i = p; aluout_i = al; readdata_i = rd; writedata_i = wd;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        tick(); tick();
        n_cmp++; if ({busy_o, done_o, pass_o, timeout_o, err_cnt_o} !== 6'b0) begin
            n_bad++; $display("FAIL reset_outs got %b want 000000",
                              {busy_o, done_o, pass_o, timeout_o, err_cnt_o}); end
        n_cmp++; if ({first_err_idx_o, first_err_obs_o} !== '0) begin
            n_bad++; $display("FAIL reset_first got %0h/%0h want 0/0",
                              first_err_idx_o, first_err_obs_o); end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_store_load_pass();
        write_entry(3'd0, 2'd0, 32'h0c, 32'd4, 32'd5);
        write_entry(3'd1, 2'd1, 32'h10, 32'd4, 32'd5);
        drive(32'h0, 32'h0, 32'h0, 32'h0);
        do_start(4'd2);
        n_cmp++; if (busy_o !== 1'b1 || done_o !== 1'b0) begin
            n_bad++; $display("FAIL sl_busy got %b%b want 10", busy_o, done_o); end
        drive(32'h0c, 32'd4, 32'd0, 32'd5); tick();
        drive(32'h10, 32'd4, 32'd5, 32'd0); tick();
        drive(32'h0, 32'd0, 32'd0, 32'd0);
        n_cmp++; if (done_o !== 1'b0) begin
            n_bad++; $display("FAIL sl_early_done got %b want 0", done_o); end
        tick();
        n_cmp++; if ({done_o, pass_o, busy_o, err_cnt_o} !== 5'b11000) begin
            n_bad++; $display("FAIL sl_pass got %b want 11000",
                              {done_o, pass_o, busy_o, err_cnt_o}); end
    endtask

    task automatic test_data_mismatch();
        do_start(4'd2);
        drive(32'h0c, 32'd4, 32'd0, 32'd6); tick();
        n_cmp++; if (err_cnt_o !== 2'd1) begin
            n_bad++; $display("FAIL dm_err_latency got %0d want 1", err_cnt_o); end
        drive(32'h10, 32'd4, 32'd5, 32'd0); tick();
        drive(32'h0, 32'd0, 32'd0, 32'd0); tick();
        n_cmp++; if ({done_o, pass_o, err_cnt_o} !== 4'b1001) begin
            n_bad++; $display("FAIL dm_result got %b want 1001", {done_o, pass_o, err_cnt_o}); end
`ifdef TRACE_CHK_FIRSTERR_EN
        n_cmp++; if (first_err_idx_o !== 3'd0 || first_err_obs_o !== 32'd6) begin
            n_bad++; $display("FAIL dm_first got %0d/%0h want 0/6",
                              first_err_idx_o, first_err_obs_o); end
`else
        n_cmp++; if ({first_err_idx_o, first_err_obs_o} !== '0) begin
            n_bad++; $display("FAIL dm_first_off got %0d/%0h want 0/0",
                              first_err_idx_o, first_err_obs_o); end
`endif
    endtask

    task automatic test_len_zero();
        do_start(4'd0);
        n_cmp++; if ({done_o, pass_o, busy_o, timeout_o, err_cnt_o} !== 6'b110000) begin
            n_bad++; $display("FAIL len0 got %b want 110000",
                              {done_o, pass_o, busy_o, timeout_o, err_cnt_o}); end
    endtask

    task automatic test_branch();
        int waited;
        do_reset();
        write_entry(3'd0, 2'd2, 32'h28, 32'h34, 32'h0);
        write_entry(3'd1, 2'd3, 32'h34, 32'h04, 32'h0);
        drive(32'h0, 32'h0, 32'h0, 32'h0);
        do_start(4'd2);
        drive(32'h28, 32'h0, 32'h0, 32'h0); tick();
        n_cmp++; if (busy_o !== 1'b1) begin
            n_bad++; $display("FAIL br_busy got %b want 1", busy_o); end
        drive(32'h34, 32'h0, 32'h0, 32'h0); tick();
        tick();
        drive(32'h04, 32'h0, 32'h0, 32'h0); tick();
        drive(32'h0, 32'h0, 32'h0, 32'h0); tick();
        n_cmp++; if ({done_o, pass_o, err_cnt_o} !== 4'b1100) begin
            n_bad++; $display("FAIL br_pass got %b want 1100", {done_o, pass_o, err_cnt_o}); end
        // Wrong branch target, then a stall waiting for 0x34.
        do_start(4'd2);
        drive(32'h28, 32'h0, 32'h0, 32'h0); tick();
        drive(32'h2c, 32'h0, 32'h0, 32'h0); tick();
        n_cmp++; if (err_cnt_o !== 2'd1) begin
            n_bad++; $display("FAIL br_err got %0d want 1", err_cnt_o); end
        drive(32'h0, 32'h0, 32'h0, 32'h0);
        waited = 0;
        while (!done_o && waited < 20) begin
            tick();
            waited++;
        end
        n_cmp++; if (waited !== 8) begin
            n_bad++; $display("FAIL br_timeout_cycles got %0d want 8", waited); end
        n_cmp++; if ({done_o, timeout_o, pass_o, err_cnt_o} !== 5'b11001) begin
            n_bad++; $display("FAIL br_timeout got %b want 11001",
                              {done_o, timeout_o, pass_o, err_cnt_o}); end
`ifdef TRACE_CHK_FIRSTERR_EN
        n_cmp++; if (first_err_idx_o !== 3'd0 || first_err_obs_o !== 32'h2c) begin
            n_bad++; $display("FAIL br_first got %0d/%0h want 0/2c",
                              first_err_idx_o, first_err_obs_o); end
`endif
    endtask

    task automatic test_timeout();
        do_reset();
        write_entry(3'd0, 2'd0, 32'h40, 32'h11, 32'h22);
        drive(32'h0, 32'h0, 32'h0, 32'h0);
        do_start(4'd1);
        for (int i = 0; i < 7; i++) tick();
        n_cmp++; if (done_o !== 1'b0 || busy_o !== 1'b1) begin
            n_bad++; $display("FAIL to_early got done=%b busy=%b want 0/1", done_o, busy_o); end
        tick();
        n_cmp++; if ({done_o, timeout_o, pass_o, busy_o} !== 4'b1100) begin
            n_bad++; $display("FAIL to_end got %b want 1100",
                              {done_o, timeout_o, pass_o, busy_o}); end
        // Match exactly on the timeout boundary wins.
        do_start(4'd1);
        for (int i = 0; i < 7; i++) tick();
        drive(32'h40, 32'h11, 32'h0, 32'h22); tick();
        n_cmp++; if (timeout_o !== 1'b0 || busy_o !== 1'b1) begin
            n_bad++; $display("FAIL to_prio got to=%b busy=%b want 0/1", timeout_o, busy_o); end
        drive(32'h0, 32'h0, 32'h0, 32'h0); tick();
        n_cmp++; if ({done_o, pass_o, timeout_o} !== 3'b110) begin
            n_bad++; $display("FAIL to_prio_end got %b want 110", {done_o, pass_o, timeout_o}); end
    endtask

    task automatic test_saturation_reset();
        logic [1:0] exp_err;
        do_reset();
        for (int i = 0; i < 5; i++)
            write_entry(AW'(i), 2'd0, 32'h100 + 32'(4 * i), 32'(i), 32'h0);
        drive(32'h0, 32'h0, 32'h0, 32'h0);
        do_start(4'd5);
        for (int i = 0; i < 5; i++) begin
            drive(32'h100 + 32'(4 * i), 32'hff, 32'h0, 32'h0); tick();
            exp_err = (i >= 2) ? 2'd3 : 2'(i + 1);
            n_cmp++; if (err_cnt_o !== exp_err) begin
                n_bad++; $display("FAIL sat_step%0d got %0d want %0d", i, err_cnt_o, exp_err); end
        end
        drive(32'h0, 32'h0, 32'h0, 32'h0); tick();
        n_cmp++; if ({done_o, pass_o, err_cnt_o} !== 4'b1011) begin
            n_bad++; $display("FAIL sat_end got %b want 1011", {done_o, pass_o, err_cnt_o}); end
`ifdef TRACE_CHK_FIRSTERR_EN
        n_cmp++; if (first_err_idx_o !== 3'd0 || first_err_obs_o !== 32'hff) begin
            n_bad++; $display("FAIL sat_first got %0d/%0h want 0/ff",
                              first_err_idx_o, first_err_obs_o); end
`endif
        // Asynchronous reset in the middle of a run.
        do_start(4'd5);
        drive(32'h100, 32'hff, 32'h0, 32'h0); tick();
        rst_ni = 1'b0;
        #1;
        n_cmp++; if ({busy_o, done_o, pass_o, timeout_o, err_cnt_o, first_err_idx_o,
                      first_err_obs_o} !== '0) begin
            n_bad++; $display("FAIL midrun_reset got b%b d%b p%b t%b e%0d i%0d o%0h want all 0",
                              busy_o, done_o, pass_o, timeout_o, err_cnt_o, first_err_idx_o,
                              first_err_obs_o); end
        tick();
        rst_ni = 1'b1;
        do_start(4'd5);
        for (int i = 0; i < 5; i++) begin
            drive(32'h100 + 32'(4 * i), 32'(i), 32'h0, 32'h0); tick();
        end
        drive(32'h0, 32'h0, 32'h0, 32'h0); tick();
        n_cmp++; if ({done_o, pass_o, err_cnt_o} !== 4'b1100) begin
            n_bad++; $display("FAIL post_reset_run got %b want 1100", {done_o, pass_o, err_cnt_o}); end
    endtask

    task automatic test_cfg_we_locked();
        do_reset();
        write_entry(3'd0, 2'd0, 32'h200, 32'd7, 32'd8);
        drive(32'h0, 32'h0, 32'h0, 32'h0);
        do_start(4'd1);
        write_entry(3'd0, 2'd0, 32'h300, 32'd9, 32'd9);  // during RUN
        drive(32'h200, 32'd7, 32'd0, 32'd8); tick();
        drive(32'h0, 32'h0, 32'h0, 32'h0); tick();
        n_cmp++; if ({done_o, pass_o} !== 2'b11) begin
            n_bad++; $display("FAIL we_run got %b want 11", {done_o, pass_o}); end
        write_entry(3'd0, 2'd0, 32'h300, 32'd9, 32'd9);  // during DONE
        do_start(4'd1);
        drive(32'h200, 32'd7, 32'd0, 32'd8); tick();
        drive(32'h0, 32'h0, 32'h0, 32'h0); tick();
        n_cmp++; if ({done_o, pass_o, timeout_o, err_cnt_o} !== 5'b11000) begin
            n_bad++; $display("FAIL we_rerun got %b want 11000",
                              {done_o, pass_o, timeout_o, err_cnt_o}); end
    endtask

    initial begin
        test_reset();
        test_store_load_pass();
        test_data_mismatch();
        test_len_zero();
        test_branch();
        test_timeout();
        test_saturation_reset();
        test_cfg_we_locked();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
